adc_snapshot_capture: RTL

- Triggered snapshot buffer downstream of the IF data-process top. Consumes the selected 16-bit signed ADC output pair (raw or DC-offset-corrected) on sys_clk.
- On a MIF-armed trigger, stores a fixed-length burst of {A,B} samples into on-chip RAM. The MIF/host then reads the burst back for spectrum and DC inspection.

---
 rtl/adc_cap_pkg.sv | 36 +++
 rtl/adc_cap_ram.sv | 41 ++++
 rtl/adc_snapshot_capture.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_cap_pkg.sv
// ============================================================================
// Module      : adc_cap_pkg
// Description : Shared state encodings, trigger modes and length helper for
//               the ADC snapshot capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_cap_pkg;

    localparam int CAP_ADDR_W_DEF = 10;
    localparam int CAP_TS_W_DEF   = 32;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    localparam logic [1:0] TRIG_IMM    = 2'd0;
    localparam logic [1:0] TRIG_THRESH = 2'd1;
    localparam logic [1:0] TRIG_EXT    = 2'd2;

    // Zero or an oversized request both mean "fill the whole RAM".
    function automatic int unsigned cap_eff_len(input int unsigned len,
                                                input int unsigned depth);
        if ((len == 0) || (len > depth)) begin
            return depth;
        end
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_cap_ram.sv
// ============================================================================
// Module      : adc_cap_ram
// Description : Simple dual-port snapshot RAM, one write port and one
//               registered read-first read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_cap_ram
    import adc_cap_pkg::*;
#(
    parameter int ADDR_W = CAP_ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Both accesses in one process: a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/adc_snapshot_capture.sv
// ============================================================================
// Module      : adc_snapshot_capture
// Description : Triggered {A,B} snapshot buffer with MIF readback.
//               Optional decimation enabled by macro ADC_CAP_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_snapshot_capture
    import adc_cap_pkg::*;
#(
    parameter int ADDR_W = CAP_ADDR_W_DEF,
    parameter int TS_W   = CAP_TS_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [15:0]       adc_data_a,
    input  logic [15:0]       adc_data_b,
    input  logic              ext_trig,
    input  logic              mif_cap_arm,
    input  logic              mif_cap_abort,
    input  logic [1:0]        mif_cap_trig_mode,
    input  logic [15:0]       mif_cap_thresh,
    input  logic [ADDR_W:0]   mif_cap_len,
`ifdef ADC_CAP_DECIM_EN
    input  logic [7:0]        mif_cap_decim,
`endif
    input  logic              mif_rd_en,
    input  logic [ADDR_W-1:0] mif_rd_addr,
    output logic [31:0]       mif_rd_data,
    output logic              mif_rd_valid,
    output logic [1:0]        cap_state,
    output logic              cap_done,
    output logic [TS_W-1:0]   cap_trig_ts,
    output logic [199:0]      debug_signal
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int LEN_W = ADDR_W + 1;

    logic [15:0]       r_a_s1;
    logic [15:0]       r_b_s1;
    logic [TS_W-1:0]   r_ts;
    logic [TS_W-1:0]   r_trig_ts;
    logic              r_ext_sync1;
    logic              r_ext_sync2;
    logic              r_ext_prev;
    logic              r_ext_rise;
    cap_state_t        r_state;
    cap_state_t        w_next_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_eff;
    logic              w_we;
    logic              w_arm_accept;
    logic              w_trig_fire;
    logic              w_trig;
    logic              w_do_write;
    logic              w_last;
    logic [15:0]       w_abs_a;
    logic [31:0]       w_ram_rdata;
    logic              r_rd_v1;
    logic              r_rd_valid;
    logic [31:0]       r_rd_data;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_a_s1      <= '0;
            r_b_s1      <= '0;
            r_ts        <= '0;
            r_ext_sync1 <= 1'b0;
            r_ext_sync2 <= 1'b0;
            r_ext_prev  <= 1'b0;
            r_ext_rise  <= 1'b0;
        end else begin
            r_a_s1      <= adc_data_a;
            r_b_s1      <= adc_data_b;
            r_ts        <= r_ts + TS_W'(1);
            r_ext_sync1 <= ext_trig;
            r_ext_sync2 <= r_ext_sync1;
            r_ext_prev  <= r_ext_sync2;
            r_ext_rise  <= r_ext_sync2 & ~r_ext_prev;
        end
    end

    // -32768 has no positive 16-bit twin, so it pins to full scale.
    assign w_abs_a = (r_a_s1 == 16'h8000) ? 16'h7FFF :
                     (r_a_s1[15] ? (16'd0 - r_a_s1) : r_a_s1);

    always_comb begin
        w_trig = 1'b1;
        case (mif_cap_trig_mode)
            TRIG_THRESH: w_trig = (w_abs_a >= mif_cap_thresh);
            TRIG_EXT:    w_trig = r_ext_rise;
            default:     w_trig = 1'b1;
        endcase
    end

    assign w_len_eff = LEN_W'(cap_eff_len(32'(mif_cap_len), DEPTH));
    assign w_last    = ({1'b0, r_waddr} == (r_len - LEN_W'(1)));

`ifdef ADC_CAP_DECIM_EN
    logic [7:0] r_decim;
    logic [7:0] r_phase;

    assign w_do_write = (r_phase == r_decim);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_decim <= '0;
            r_phase <= '0;
        end else begin
            if (w_arm_accept) begin
                r_decim <= mif_cap_decim;
            end
            if (w_trig_fire) begin
                r_phase <= '0;
            end else if (r_state == CAP_CAPTURE) begin
                r_phase <= w_do_write ? 8'd0 : (r_phase + 8'd1);
            end
        end
    end
`else
    assign w_do_write = 1'b1;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_wr_addr    = r_waddr;
        w_arm_accept = 1'b0;
        w_trig_fire  = 1'b0;
        case (r_state)
            CAP_IDLE: begin
                if (mif_cap_arm) begin
                    w_next_state = CAP_ARMED;
                    w_arm_accept = 1'b1;
                end
            end
            CAP_ARMED: begin
                if (w_trig) begin
                    w_we         = 1'b1;
                    w_wr_addr    = '0;
                    w_trig_fire  = 1'b1;
                    w_next_state = (r_len == LEN_W'(1)) ? CAP_DONE : CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                if (w_do_write) begin
                    w_we = 1'b1;
                    if (w_last) begin
                        w_next_state = CAP_DONE;
                    end
                end
            end
            CAP_DONE: begin
                if (mif_cap_arm) begin
                    w_next_state = CAP_ARMED;
                    w_arm_accept = 1'b1;
                end
            end
            default: w_next_state = CAP_IDLE;
        endcase
        if (mif_cap_abort) begin
            w_next_state = CAP_IDLE;
            w_we         = 1'b0;
            w_arm_accept = 1'b0;
            w_trig_fire  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_waddr   <= '0;
            r_len     <= '0;
            r_trig_ts <= '0;
        end else begin
            if (w_arm_accept) begin
                r_len   <= w_len_eff;
                r_waddr <= '0;
            end else if (w_trig_fire) begin
                r_trig_ts <= r_ts;
                r_waddr   <= ADDR_W'(1);
            end else if (w_we) begin
                r_waddr <= r_waddr + ADDR_W'(1);
            end
        end
    end

    adc_cap_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clk     (sys_clk),
        .i_we    (w_we),
        .i_waddr (w_wr_addr),
        .i_wdata ({r_a_s1, r_b_s1}),
        .i_re    (mif_rd_en),
        .i_raddr (mif_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_v1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= mif_rd_en;
            r_rd_valid <= r_rd_v1;
            r_rd_data  <= w_ram_rdata;
        end
    end

    assign mif_rd_data  = r_rd_data;
    assign mif_rd_valid = r_rd_valid;
    assign cap_state    = r_state;
    assign cap_done     = (r_state == CAP_DONE);
    assign cap_trig_ts  = r_trig_ts;

    assign debug_signal = {48'd0, 32'(r_ts), 32'(r_trig_ts), r_a_s1, r_b_s1,
                           16'(r_waddr), 16'(r_len), w_abs_a, r_state,
                           r_ext_prev, r_ext_rise, r_ext_sync2, r_ext_sync1,
                           w_we, r_rd_v1};

endmodule

`default_nettype wire
